// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with first-word-fall-through receive buffer.
//   Deserialises rx (idle high, LSB first, optional parity, 1 or 2 stop bits)
//   and stores {ferr, perr, data} entries for the core's UART register file.
//   Build option: define UART_RX_FIFO_EN for a DEPTH-entry circular buffer;
//   when undefined a single holding register is used instead.
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   rx                 serial input (asynchronous to clk)
//   baudcontrol        bit period minus one, in clk cycles
//   parity             00/11 none, 01 odd, 10 even
//   stop_sel           0 = one stop bit, 1 = two stop bits
//   rd_en              pop head entry (ignored when empty)
//   clr_err            clear sticky overrun
//   dout/_perr/_ferr   head entry (zero when empty)
//   empty, full, count buffer status
//   overrun            sticky byte-dropped flag
//   busy               receiver not idle
module uart_rx_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned BAUD_W = 24
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     rx,
   input  logic [BAUD_W-1:0]        baudcontrol,
   input  logic [1:0]               parity,
   input  logic                     stop_sel,
   input  logic                     rd_en,
   input  logic                     clr_err,
   output logic [7:0]               dout,
   output logic                     dout_perr,
   output logic                     dout_ferr,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun,
   output logic                     busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = 10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP1 = 3'd4;
   localparam logic [2:0] S_STOP2 = 3'd5;

   // Two-flop synchroniser plus previous-sample register for edge detect
   logic sync1_q, rxs_q, rxs_prev_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync1_q    <= rx;
         rxs_q      <= sync1_q;
         rxs_prev_q <= rxs_q;
      end
   end

   logic [2:0]        state_q, state_d;
   logic [BAUD_W-1:0] cnt_q, cnt_d;
   logic [BAUD_W-1:0] bc_q, bc_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [7:0]        data_q, data_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic              brk_q, brk_d;
   logic [1:0]        par_q, par_d;
   logic              stop_q, stop_d;
   logic              commit_c;
   logic              wr_ferr_c;
   logic              wr_q;
   logic [EW-1:0]     wr_data_q;

   logic cnt_zero;
   assign cnt_zero = (cnt_q == '0);

   // Receiver next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bc_d      = bc_q;
      bitcnt_d  = bitcnt_q;
      data_d    = data_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      brk_d     = brk_q;
      par_d     = par_q;
      stop_d    = stop_q;
      commit_c  = 1'b0;
      wr_ferr_c = ferr_q;
      if (state_q != S_IDLE && !cnt_zero) begin
         cnt_d = cnt_q - BAUD_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            // After a frame ending low, wait for the line to go high again
            if (rxs_q) begin
               brk_d = 1'b0;
            end
            if (!brk_q && rxs_prev_q && !rxs_q) begin
               state_d  = S_START;
               cnt_d    = baudcontrol >> 1;
               bc_d     = baudcontrol;
               par_d    = parity;
               stop_d   = stop_sel;
               bitcnt_d = 3'd0;
               perr_d   = 1'b0;
               ferr_d   = 1'b0;
            end
         end
         S_START: begin
            if (cnt_zero) begin
               if (!rxs_q) begin
                  state_d = S_DATA;
                  cnt_d   = bc_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (cnt_zero) begin
               data_d   = {rxs_q, data_q[7:1]};
               cnt_d    = bc_q;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = (par_q[0] ^ par_q[1]) ? S_PAR : S_STOP1;
               end
            end
         end
         S_PAR: begin
            if (cnt_zero) begin
               perr_d  = ((^data_q) ^ rxs_q) != (par_q == 2'b01);
               cnt_d   = bc_q;
               state_d = S_STOP1;
            end
         end
         S_STOP1: begin
            if (cnt_zero) begin
               ferr_d = !rxs_q;
               if (stop_q) begin
                  cnt_d   = bc_q;
                  state_d = S_STOP2;
               end else begin
                  wr_ferr_c = !rxs_q;
                  commit_c  = 1'b1;
                  brk_d     = !rxs_q;
                  state_d   = S_IDLE;
               end
            end
         end
         S_STOP2: begin
            if (cnt_zero) begin
               ferr_d    = ferr_q | !rxs_q;
               wr_ferr_c = ferr_q | !rxs_q;
               commit_c  = 1'b1;
               brk_d     = !rxs_q;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bc_q      <= '0;
         bitcnt_q  <= 3'd0;
         data_q    <= 8'd0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         brk_q     <= 1'b0;
         par_q     <= 2'b00;
         stop_q    <= 1'b0;
         wr_q      <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bc_q      <= bc_d;
         bitcnt_q  <= bitcnt_d;
         data_q    <= data_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         brk_q     <= brk_d;
         par_q     <= par_d;
         stop_q    <= stop_d;
         // Commit is staged one cycle so the buffer write is registered
         wr_q      <= commit_c;
         wr_data_q <= {wr_ferr_c, perr_q, data_q};
      end
   end

   assign busy = (state_q != S_IDLE);

   logic          overrun_q, overrun_d;
   logic          pop_c, push_c, drop_c;
   logic [EW-1:0] head_c;

`ifdef UART_RX_FIFO_EN
   localparam int unsigned PW = $clog2(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign count  = count_q;
   assign head_c = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot for a commit on a full buffer
   always_comb begin
      pop_c    = rd_en && !empty;
      push_c   = wr_q && (!full || pop_c);
      drop_c   = wr_q && !push_c;
      wr_ptr_d = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_c && !pop_c) begin
         count_d = count_q + CW'(1);
      end else if (pop_c && !push_c) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, no reset needed: entries are only read when counted valid
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr_data_q;
      end
   end
`else
   logic          hold_valid_q, hold_valid_d;
   logic [EW-1:0] hold_q, hold_d;

   assign empty  = !hold_valid_q;
   assign full   = hold_valid_q;
   assign count  = CW'(hold_valid_q);
   assign head_c = hold_q;

   // Occupied register keeps the old byte unless it is popped this cycle
   always_comb begin
      pop_c        = rd_en && hold_valid_q;
      push_c       = wr_q && (!hold_valid_q || pop_c);
      drop_c       = wr_q && !push_c;
      hold_valid_d = hold_valid_q;
      hold_d       = hold_q;
      if (push_c) begin
         hold_valid_d = 1'b1;
         hold_d       = wr_data_q;
      end else if (pop_c) begin
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_q       <= hold_d;
      end
   end
`endif

   // A drop in the same cycle as clr_err keeps overrun set
   always_comb begin
      overrun_d = overrun_q;
      if (drop_c) begin
         overrun_d = 1'b1;
      end else if (clr_err) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun   = overrun_q;
   assign dout      = empty ? 8'd0 : head_c[7:0];
   assign dout_perr = !empty && head_c[8];
   assign dout_ferr = !empty && head_c[9];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: framing, parity, break, glitch,
// overflow, same-cycle pop/commit and mid-frame reset.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned BAUD_W = 24;
   localparam int unsigned BC     = 15;
   localparam int unsigned T      = BC + 1;

`ifdef UART_RX_FIFO_EN
   localparam int unsigned EXP_DEPTH = 16;
`else
   localparam int unsigned EXP_DEPTH = 1;
`endif

   logic                   clk;
   logic                   nrst;
   logic                   rx;
   logic [BAUD_W-1:0]      baudcontrol;
   logic [1:0]             parity;
   logic                   stop_sel;
   logic                   rd_en;
   logic                   clr_err;
   logic [7:0]             dout;
   logic                   dout_perr;
   logic                   dout_ferr;
   logic                   empty;
   logic                   full;
   logic [$clog2(DEPTH):0] count;
   logic                   overrun;
   logic                   busy;

   int n_cmp;
   int n_err;
   bit hit;
   bit saw;

   uart_rx_fifo #(.DEPTH(DEPTH), .BAUD_W(BAUD_W)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .rx          (rx),
      .baudcontrol (baudcontrol),
      .parity      (parity),
      .stop_sel    (stop_sel),
      .rd_en       (rd_en),
      .clr_err     (clr_err),
      .dout        (dout),
      .dout_perr   (dout_perr),
      .dout_ferr   (dout_ferr),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overrun     (overrun),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_dout"},    32'(dout),      32'h0);
      chk({tag, "_perr"},    32'(dout_perr), 32'h0);
      chk({tag, "_ferr"},    32'(dout_ferr), 32'h0);
      chk({tag, "_empty"},   32'(empty),     32'h1);
      chk({tag, "_full"},    32'(full),      32'h0);
      chk({tag, "_count"},   32'(count),     32'h0);
      chk({tag, "_overrun"}, 32'(overrun),   32'h0);
      chk({tag, "_busy"},    32'(busy),      32'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_out(input logic b);
      rx = b;
      repeat (T) @(negedge clk);
   endtask

   // One frame; rx is left at the last stop-bit level
   task automatic send(input logic [7:0] d, input bit has_p, input bit p,
                       input bit s1, input bit has_s2, input bit s2);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
      if (has_p) bit_out(p);
      bit_out(s1);
      if (has_s2) bit_out(s2);
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      n_cmp       = 0;
      n_err       = 0;
      nrst        = 1'b0;
      rx          = 1'b1;
      baudcontrol = BAUD_W'(BC);
      parity      = 2'b00;
      stop_sel    = 1'b0;
      rd_en       = 1'b0;
      clr_err     = 1'b0;
      idle(3);
      chk_reset("reset");
      nrst = 1'b1;
      idle(4);

      // Basic frame, no parity, one stop bit
      send(8'hA5, 0, 0, 1, 0, 0);
      idle(4);
      chk("a5_empty", 32'(empty),     32'h0);
      chk("a5_dout",  32'(dout),      32'hA5);
      chk("a5_perr",  32'(dout_perr), 32'h0);
      chk("a5_ferr",  32'(dout_ferr), 32'h0);
      chk("a5_count", 32'(count),     32'h1);
      pop();
      chk("a5_pop_empty", 32'(empty), 32'h1);
      chk("a5_pop_dout",  32'(dout),  32'h0);

      // Even parity: 0x07 has three ones
      parity = 2'b10;
      send(8'h07, 1, 0, 1, 0, 0);
      idle(4);
      chk("even_p0_dout", 32'(dout),      32'h07);
      chk("even_p0_perr", 32'(dout_perr), 32'h1);
      pop();
      send(8'h07, 1, 1, 1, 0, 0);
      idle(4);
      chk("even_p1_dout", 32'(dout),      32'h07);
      chk("even_p1_perr", 32'(dout_perr), 32'h0);
      pop();
      // Odd parity
      parity = 2'b01;
      send(8'h07, 1, 0, 1, 0, 0);
      idle(4);
      chk("odd_p0_dout", 32'(dout),      32'h07);
      chk("odd_p0_perr", 32'(dout_perr), 32'h0);
      pop();
      send(8'h07, 1, 1, 1, 0, 0);
      idle(4);
      chk("odd_p1_dout", 32'(dout),      32'h07);
      chk("odd_p1_perr", 32'(dout_perr), 32'h1);
      pop();
      chk("parity_drained", 32'(empty), 32'h1);

      // Two stop bits, second one low, line held low afterwards
      parity   = 2'b00;
      stop_sel = 1'b1;
      send(8'h3C, 0, 0, 1, 1, 0);
      idle(40);
      chk("brk_busy",  32'(busy),      32'h0);
      chk("brk_count", 32'(count),     32'h1);
      chk("brk_dout",  32'(dout),      32'h3C);
      chk("brk_ferr",  32'(dout_ferr), 32'h1);
      rx = 1'b1;
      idle(40);
      chk("brk_rel_count", 32'(count), 32'h1);
      chk("brk_rel_busy",  32'(busy),  32'h0);
      pop();
      stop_sel = 1'b0;

      // Glitch: four cycles low
      saw = 1'b0;
      rx  = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 3) rx = 1'b1;
         if (busy) saw = 1'b1;
      end
      chk("glitch_busy_seen", 32'(saw),   32'h1);
      chk("glitch_busy_end",  32'(busy),  32'h0);
      chk("glitch_empty",     32'(empty), 32'h1);

      // Overflow: 17 bytes without reading
      for (int i = 0; i < 17; i++) begin
         b = 8'(i);
         send(b, 0, 0, 1, 0, 0);
         idle(2);
      end
      idle(4);
      chk("ovf_full",    32'(full),    32'h1);
      chk("ovf_count",   32'(count),   32'(EXP_DEPTH));
      chk("ovf_overrun", 32'(overrun), 32'h1);
      for (int i = 0; i < int'(EXP_DEPTH); i++) begin
         chk("ovf_head", 32'(dout), 32'(i));
         pop();
      end
      chk("ovf_drained", 32'(empty),   32'h1);
      chk("ovf_still",   32'(overrun), 32'h1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("ovf_clr", 32'(overrun), 32'h0);

      // Fill, then pop in the same cycle as the extra commit
      for (int i = 0; i < int'(EXP_DEPTH); i++) begin
         b = 8'(8'h40 + i);
         send(b, 0, 0, 1, 0, 0);
         idle(2);
      end
      chk("fill_full", 32'(full), 32'h1);
      b   = 8'(8'h40 + EXP_DEPTH);
      hit = 1'b0;
      fork
         send(b, 0, 0, 1, 0, 0);
         begin : watch
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 400 && !hit; k++) begin
               @(negedge clk);
               if (busy) begin
                  seen = 1'b1;
               end else if (seen) begin
                  // busy has just fallen: the staged write happens next edge
                  rd_en = 1'b1;
                  @(negedge clk);
                  rd_en = 1'b0;
                  hit   = 1'b1;
               end
            end
         end
      join
      idle(4);
      chk("same_hit",     32'(hit),     32'h1);
      chk("same_overrun", 32'(overrun), 32'h0);
      chk("same_count",   32'(count),   32'(EXP_DEPTH));
      chk("same_head",    32'(dout),    32'h41);

      // Reset in the middle of a frame with a full buffer
      rx = 1'b0;
      idle(40);
      chk("mid_busy", 32'(busy), 32'h1);
      nrst = 1'b0;
      idle(2);
      chk_reset("midrst");
      rx   = 1'b1;
      nrst = 1'b1;
      idle(40);
      chk("post_busy",  32'(busy),  32'h0);
      chk("post_empty", 32'(empty), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive stage for the RV32IMC SoC: deserialises the board RX pin (ck_io8) into bytes and buffers them for the core's UART peripheral register file. It sits directly upstream of the core's load path. The UART TX stage and the bench's serial monitor use the same framing convention: LSB first, configurable parity, and 1 or 2 stop bits. Received bytes are held in a 16-deep first-word-fall-through buffer with per-byte error flags.

## Interface
- DEPTH, 16, buffer entries (power of two, ≥2)
- BAUD_W, 24, width of baud divisor
- clk  in  1  system clock
- nrst  in  1  reset; asynchronous, active-low
- rx  in  1  serial input, idle high, asynchronous to clk
- baudcontrol  in  BAUD_W  bit period minus one, in clk cycles (5207 gives 9600 bd at 50 MHz)
- parity  in  2  00/11 none, 01 odd, 10 even
- stop_sel  in  1  0 = one stop bit, 1 = two stop bits
- rd_en  in  1  pop head entry; ignored when empty
- clr_err  in  1  clears sticky overrun flag
- dout  out  8  head byte; 0 when empty
- dout_perr  out  1  head byte parity error
- dout_ferr  out  1  head byte framing error
- empty  out  1  buffer empty
- full  out  1  buffer full
- count  out  $clog2(DEPTH)+1  occupancy
- overrun  out  1  sticky: a byte was dropped because the buffer was full
- busy  out  1  receiver not IDLE

## Operation
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, PAR, STOP1, STOP2.
- IDLE: rxs falling edge → START; bit counter = baudcontrol>>1.
- START: at count 0, rxs==0 → DATA with counter = baudcontrol; rxs==1 → glitch, back to IDLE, nothing stored.
- DATA: sample at each counter 0 and reload the counter with baudcontrol. Bits shift in LSB first. After 8 samples: PAR if parity∈{01,10}, else STOP1.
- PAR: sample p. perr = (^data ^ p) != (parity==01). Odd parity requires data+p to have an odd count of ones.
- STOP1: sample; ferr = !rxs. Then STOP2 if stop_sel, else commit.
- STOP2: sample; ferr |= !rxs; then commit.
- Commit: the entry {ferr, perr, data} is written to the buffer. Return to IDLE. If the last stop sample was 0, IDLE waits until rxs==1 before arming edge detect, so a break condition does not retrigger.
- Buffer: circular, pointers wrap modulo DEPTH. Write when committing and not full. A commit while full drops the byte and sets overrun. overrun clears on clr_err, unless a new drop happens the same cycle, in which case the drop wins.
- Commit and rd_en in the same cycle: both happen and count is unchanged. When full, the pop frees the slot, so the write is accepted and overrun is not set.
- rd_en while empty: no effect.
- baudcontrol, parity and stop_sel are sampled only in IDLE on the start edge and held for the whole frame.

## Timing
- Reset values: dout=0, dout_perr=0, dout_ferr=0, empty=1, full=0, count=0, overrun=0, busy=0. FSM=IDLE, pointers=0, synchroniser=1.
- Reset asserted mid-frame: the partial byte is discarded and the buffer is cleared.
- Bit period T = baudcontrol+1 cycles. The start bit is verified ≈T/2 after the synchronised edge, so each data sample lands at mid-bit.
- Latency from the rx falling edge to empty deasserting is 2 (sync) + 1 (edge) + (baudcontrol>>1)+1 + N·T + 1 cycles, where N = 8 + parity bit + stop bits.
- The buffer is first-word-fall-through: dout is valid combinationally from the head whenever !empty. After rd_en, the next entry appears on the following cycle.
- Flags are registered and update the cycle after a commit or pop.

## Configuration
- UART_RX_FIFO_EN defined: DEPTH-entry buffer as above.
- UART_RX_FIFO_EN undefined: a single holding register replaces the buffer. DEPTH is ignored, full = !empty, and count ∈ {0,1}. A commit while the register is full sets overrun and keeps the old byte, unless rd_en is asserted that cycle. All other behaviour is identical.

## Test plan
- baudcontrol=15, parity=00, stop_sel=0, send 0xA5 → after one frame: empty=0, dout=0xA5, perr=0, ferr=0, count=1. Then rd_en → empty=1, dout=0.
- parity=10 (even), send 0x07 with parity bit 0 → dout=0x07, dout_perr=1. Resend with parity bit 1 → dout_perr=0. Repeat with parity=01 and both flags invert.
- stop_sel=1, send 0x3C with the second stop bit driven 0 → dout_ferr=1. The receiver stays IDLE until rx returns high and no spurious byte is stored.
- Glitch: pull rx low for 4 cycles with baudcontrol=15 → busy pulses, no entry is stored, FSM returns to IDLE.
- Send 17 bytes 0x00..0x10 without reading → full=1, count=16, overrun=1, and the head pops 0x00..0x0F in order. clr_err → overrun=0.
- With the buffer full, assert rd_en in the same cycle as the 17th commit → overrun stays 0 and count stays 16. Also assert nrst mid-frame → all outputs return to their reset values.
